// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo angle ramp and its frame timer.
package servo_pkg;

    localparam int ANGLE_W = 32;

    localparam int unsigned FRAME_CYCLES_DEF = 2000000;
    localparam int unsigned STEP_DEG_DEF     = 2;
    localparam int unsigned ANGLE_MAX_DEF    = 180;
    localparam int unsigned HOME_DEG_DEF     = 90;

    // Command value that clears the sticky clamp flag instead of setting a target.
    localparam logic [ANGLE_W-1:0] CLEAR_CODE = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/servo_frame_timer.sv
// Frame counter 0..FRAME_CYCLES-1 with a registered tick on the last cycle of each frame.
// Also usable as the period timer of the PWM stage.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    output logic frame_tick
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = (count == LAST) ? '0 : count + CNT_W'(1);
    end

    // Tick is registered against the next count so it lines up with count == LAST.
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            frame_tick <= 1'b0;
        end else begin
            count      <= count_next;
            frame_tick <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/servo_angle_ramp.sv
// Clamps target-angle commands and slews angle_out toward the target at most STEP_DEG per frame,
// updating only on frame boundaries. Define SERVO_CLAMP_FLAG_EN to add the sticky clamp_err output.
module servo_angle_ramp
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int unsigned STEP_DEG     = STEP_DEG_DEF,
    parameter int unsigned ANGLE_MAX    = ANGLE_MAX_DEF,
    parameter int unsigned HOME_DEG     = HOME_DEG_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ANGLE_W-1:0] cmd_angle,
    output logic [ANGLE_W-1:0] angle_out,
    output logic               frame_tick,
    output logic               at_target,
    output logic               busy
`ifdef SERVO_CLAMP_FLAG_EN
    ,
    output logic               clamp_err
`endif
);

    localparam logic [ANGLE_W-1:0] STEP = ANGLE_W'(STEP_DEG);
    localparam logic [ANGLE_W-1:0] AMAX = ANGLE_W'(ANGLE_MAX);
    localparam logic [ANGLE_W-1:0] HOME = ANGLE_W'(HOME_DEG);

    state_t             state, state_next;
    logic [ANGLE_W-1:0] target, target_next;
    logic [ANGLE_W-1:0] pending;
    logic               pending_full;
    logic [ANGLE_W-1:0] angle_next;
    logic [ANGLE_W-1:0] cmd_clamped;
    logic               accept;
    logic               store_cmd;

    servo_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .frame_tick(frame_tick)
    );

    assign cmd_ready   = !pending_full;
    assign accept      = cmd_valid && cmd_ready;
    assign cmd_clamped = (cmd_angle > AMAX) ? AMAX : cmd_angle;
    assign at_target   = (angle_out == target) && !pending_full;
    assign busy        = (state == RAMP);

`ifdef SERVO_CLAMP_FLAG_EN
    assign store_cmd = accept && (cmd_angle != CLEAR_CODE);

    always_ff @(posedge clock) begin
        if (reset) begin
            clamp_err <= 1'b0;
        end else if (accept) begin
            if (cmd_angle == CLEAR_CODE) begin
                clamp_err <= 1'b0;
            end else if (cmd_angle > AMAX) begin
                clamp_err <= 1'b1;
            end
        end
    end
`else
    assign store_cmd = accept;
`endif

    // Movement uses the target held before the edge; a promotion only affects the next frame.
    always_comb begin
        angle_next = angle_out;
        if (frame_tick) begin
            if (target >= angle_out) begin
                angle_next = (target - angle_out <= STEP) ? target : angle_out + STEP;
            end else begin
                angle_next = (angle_out - target <= STEP) ? target : angle_out - STEP;
            end
        end
    end

    always_comb begin
        target_next = (frame_tick && pending_full) ? pending : target;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (target != angle_out) state_next = RAMP;
            RAMP: if (frame_tick && (angle_next == target_next)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            angle_out    <= HOME;
            target       <= HOME;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            state     <= state_next;
            angle_out <= angle_next;
            target    <= target_next;
            if (store_cmd) begin
                pending      <= cmd_clamped;
                pending_full <= 1'b1;
            end else if (frame_tick && pending_full) begin
                pending_full <= 1'b0;
            end
        end
    end

endmodule
